// File: rtl/mc_cpu_controller_if.sv
// Memory bus between the multicycle core (master) and the shared
// 16x8 instruction/data memory (slave).
// Signals: mem_address, mem_read, mem_write, mem_write_data (core to
// memory) and mem_read_data (combinational read data, memory to core).
interface mc_cpu_controller_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] mem_address;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;

   modport master (
      output mem_address,
      output mem_read,
      output mem_write,
      output mem_write_data,
      input  mem_read_data
   );

   modport slave (
      input  mem_address,
      input  mem_read,
      input  mem_write,
      input  mem_write_data,
      output mem_read_data
   );
endinterface

// File: rtl/mc_cpu_controller.sv
// Multicycle FETCH/DECODE/EXECUTE core for the 8-bit processor.
// Ports: clk, rst (async, active high), mem (memory bus master),
// out_data/out_valid (output port + 1-cycle pulse), halted, pc (debug).
module mc_cpu_controller #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   mc_cpu_controller_if.master        mem,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_valid,
   output logic                       halted,
   output logic [ADDR_W-1:0]          pc
);
   typedef enum logic [1:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_HALT
   } state_t;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_OR  = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_JZ  = 4'h6;
   localparam logic [3:0] OP_OUT = 4'hA;
   localparam logic [3:0] OP_JMP = 4'hB;
   localparam logic [3:0] OP_LDA = 4'hC;
   localparam logic [3:0] OP_LDB = 4'hD;
   localparam logic [3:0] OP_STR = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_ir;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic              r_z;
   logic              r_c;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   logic              r_halted;

   logic [3:0]        w_op;
   logic [ADDR_W-1:0] w_opnd;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W-1:0] w_alu;
   logic              w_alu_c;
   logic              w_is_alu;
   logic              w_is_load;

   assign w_op      = r_ir[DATA_W-1 -: 4];
   assign w_opnd    = r_ir[ADDR_W-1:0];
   assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
   assign w_is_load = (w_op == OP_LDA) || (w_op == OP_LDB);

   // Result of opcodes 0-5; C defaults to its old value so the logic
   // ops leave it untouched.
   always_comb begin
      w_alu    = r_a;
      w_alu_c  = r_c;
      w_is_alu = 1'b1;
      unique case (w_op)
         OP_ADD: begin
            w_alu   = w_sum[DATA_W-1:0];
            w_alu_c = w_sum[DATA_W];
         end
         OP_SUB: begin
            w_alu   = r_a - r_b;
            w_alu_c = (r_a >= r_b);
         end
         OP_OR:   w_alu = r_a | r_b;
         OP_AND:  w_alu = r_a & r_b;
         OP_XOR:  w_alu = r_a ^ r_b;
         OP_NOT:  w_alu = ~r_a;
         default: w_is_alu = 1'b0;
      endcase
   end

   // Strobes decode straight from state, so an async reset kills an
   // in-flight STR write before the memory samples it.
   always_comb begin
      mem.mem_address    = (r_state == S_FETCH) ? r_pc : w_opnd;
      mem.mem_read       = (r_state == S_FETCH) ||
                           ((r_state == S_EXECUTE) && w_is_load);
      mem.mem_write      = (r_state == S_EXECUTE) && (w_op == OP_STR);
      mem.mem_write_data = r_a;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_FETCH;
         r_pc        <= RESET_PC;
         r_ir        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_z         <= 1'b0;
         r_c         <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         unique case (r_state)
            S_FETCH: begin
               r_ir    <= mem.mem_read_data;
               r_pc    <= r_pc + 1'b1;
               r_state <= S_DECODE;
            end
            S_DECODE: r_state <= S_EXECUTE;
            S_EXECUTE: begin
               r_state <= S_FETCH;
               if (w_is_alu) begin
                  r_a <= w_alu;
                  r_c <= w_alu_c;
                  r_z <= (w_alu == '0);
               end
               unique case (w_op)
                  OP_JZ:  if (r_z) r_pc <= w_opnd;
                  OP_OUT: begin
                     r_out_data  <= r_a;
                     r_out_valid <= 1'b1;
                  end
                  OP_JMP: r_pc <= w_opnd;
                  OP_LDA: r_a  <= mem.mem_read_data;
                  OP_LDB: r_b  <= mem.mem_read_data;
                  OP_HLT: begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign halted    = r_halted;
   assign pc        = r_pc;
endmodule

// File: doc/mc_cpu_controller.md
Name: mc_cpu_controller

Overview:
Multicycle fetch/decode/execute core for the 8-bit processor. It drives the shared 16x8 instruction/data memory, which has a combinational read and a synchronous write. It holds the PC, IR, A, B, flags and the output register, and sequences each instruction in 3 cycles. It sits directly upstream of the memory: it generates the address, read strobe and write data, and consumes read data in the same cycle.

Parameters:
DATA_W, 8, datapath/instruction width
ADDR_W, 4, memory address width (= instruction operand field width)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_address  out  ADDR_W  memory address
mem_read  out  1  high in FETCH and EXECUTE of load instructions
mem_write  out  1  memory write strobe, sampled by memory at posedge
mem_write_data  out  DATA_W  data to memory (always = A)
mem_read_data  in  DATA_W  combinational memory read data
out_data  out  DATA_W  output port register
out_valid  out  1  one-cycle pulse when out_data is updated
halted  out  1  high once HLT has executed
pc  out  ADDR_W  current PC (debug)

Behaviour:
- Instruction format: [7:4] opcode, [3:0] operand address.
- Reset, async while rst=1: state=FETCH, pc=RESET_PC, IR/A/B/out_data=0, Z=0, C=0, out_valid=0, halted=0.
- Reset mid-instruction aborts the instruction. A write in flight is suppressed because mem_write is combinational from state and is 0 in FETCH.
- FSM states: FETCH -> DECODE -> EXECUTE -> FETCH. HALT is absorbing; only rst exits it.
- FETCH:
  - mem_address=pc, mem_read=1.
  - At the edge: IR<=mem_read_data, pc<=pc+1 (mod 16, 15 wraps to 0).
- DECODE:
  - mem_address=IR[3:0], no strobes.
  - At the edge: go to EXECUTE. No register changes.
- EXECUTE:
  - mem_address=IR[3:0].
  - Actions by opcode, all registered at the edge:
    - 0 ADD: {C,A}<=A+B (9-bit)
    - 1 SUB: A<=A-B, C<=(A>=B) (no-borrow)
    - 2 OR: A<=A|B
    - 3 AND: A<=A&B
    - 4 XOR: A<=A^B
    - 5 NOT: A<=~A
    - 6 JZ: if Z, pc<=IR[3:0]
    - 7,8,9: NOP
    - A OUT: out_data<=A, out_valid<=1 for exactly the following cycle
    - B JMP: pc<=IR[3:0]
    - C LDA: mem_read=1, A<=mem_read_data
    - D LDB: mem_read=1, B<=mem_read_data
    - E STR: mem_write=1, mem_write_data=A
    - F HLT: next state HALT, halted<=1
- Flags:
  - Z<=(new A==0) on opcodes 0-5 only.
  - C is written by ADD/SUB only.
  - OR/AND/XOR/NOT leave C unchanged.
  - Loads do not affect flags.
- mem_write is high only in EXECUTE of STR, never two consecutive cycles.
- mem_read is 0 in DECODE, HALT, and EXECUTE of non-load opcodes.
- HALT: outputs hold, mem_read=0, mem_write=0, pc frozen, halted=1.
- Every instruction takes exactly 3 cycles. A jump takes effect on the next FETCH.
- Self-modifying code: a STR to an address fetched later returns the new value, since the memory write completes before the next FETCH.
- out_valid is registered and deasserts the cycle after its pulse. OUT twice in a row produces two separate pulses, 3 cycles apart.

Test Plan:
- Program CC DD 00 20 EE A0 F0, mem[12]=05, mem[13]=03, release rst at t0. Required:
  - A=05 then 08 then 0B.
  - mem[14]=0B after STR.
  - out_data=0B with a single out_valid pulse.
  - halted=1 after exactly 21 cycles.
  - pc=7 and frozen; no further mem_write.
- SUB/flags: A=03, B=03, SUB -> A=00, Z=1, C=1. Then JZ 9 -> next fetch from address 9. With A=02, B=03, SUB -> A=FF, Z=0, C=0, and JZ falls through.
- ADD carry: A=F0, B=20 -> A=10, C=1, Z=0. A following OR keeps C=1.
- PC wrap: NOPs at addresses 13..15 with JMP absent -> pc goes 15 -> 0 and fetches mem[0].
- Async reset mid-EXECUTE of STR: assert rst between edges -> mem_write drops immediately, target location unchanged, all registers 0, halted=0. Execution restarts at pc=0 after release.
- Repeated OUT (A0 A0 F0) -> two out_valid pulses 3 cycles apart, each one cycle wide, out_data equal to A.
